// File: rtl/response_arbiter_pkg.sv
// Shared bridge definitions: arbiter states, response constants, request record.
package response_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] STATUS_OK = 8'h00;
  localparam logic [7:0] SOF_D2H   = 8'h5A;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [5:0]  count;
    logic        is_read;
  } resp_req_t;

endpackage

// File: rtl/response_arbiter_picker.sv
// Round-robin priority picker: first asserted request searching upward from rr_ptr with wrap.
// Purely combinational; no backpressure of its own.
module rr_priority_picker
  import response_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      winner
);

  int idx;

  // Walk from the farthest offset down so the candidate nearest rr_ptr wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/response_arbiter.sv
// Shares one response frame builder among NUM_REQ sources: ack+latch in IDLE, build strobe next cycle,
// done one cycle after builder completion; no grant while the builder is busy. Watchdog: RESP_ARB_TIMEOUT_EN.
module response_arbiter
  import response_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             req_done,
  input  logic [NUM_REQ-1:0][7:0]        req_status,
  input  logic [NUM_REQ-1:0][7:0]        req_cmd,
  input  logic [NUM_REQ-1:0][31:0]       req_addr,
  input  logic [NUM_REQ-1:0][63:0][7:0]  req_data,
  input  logic [NUM_REQ-1:0][5:0]        req_data_count,
  input  logic [NUM_REQ-1:0]             req_is_read,
  output logic [7:0]                     fb_status_code,
  output logic [7:0]                     fb_cmd_echo,
  output logic [31:0]                    fb_addr_echo,
  output logic [63:0][7:0]               fb_response_data,
  output logic [5:0]                     fb_response_data_count,
  output logic                           fb_is_read_response,
  output logic                           fb_build_response,
  input  logic                           fb_builder_busy,
  input  logic                           fb_response_complete,
  output logic                           arb_busy,
  output logic [$clog2(NUM_REQ)-1:0]     arb_owner,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_err
    $error("response_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 2..65536");
  end

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] grant;
  resp_req_t          lat;
  logic [63:0][7:0]   lat_data;
  logic               take;
  logic               wd_fire;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (win_idx)
  );

  // Grant is held off during reset so an ack never pairs with a discarded latch.
  assign take    = !rst && (state == ST_IDLE) && !fb_builder_busy && (|req_valid);
  assign req_ack = take ? grant : '0;

  always_comb begin
    req_done = '0;
    if (state == ST_DONE) req_done[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      lat      <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            lat.status  <= req_status[win_idx];
            lat.cmd     <= req_cmd[win_idx];
            lat.addr    <= req_addr[win_idx];
            lat.count   <= req_data_count[win_idx];
            lat.is_read <= req_is_read[win_idx];
            lat_data    <= req_data[win_idx];
            owner_q     <= win_idx;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (fb_response_complete || wd_fire) state <= ST_DONE;
        end
        ST_DONE: begin
          rr_ptr <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RESP_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_err;

  assign wd_fire = (state == ST_WAIT) && !fb_response_complete &&
                   (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     wd_cnt <= '0;
      else if (state == ST_WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (wd_fire) wd_err <= 1'b1;
    end
  end

  assign timeout_err = wd_err;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign fb_status_code         = lat.status;
  assign fb_cmd_echo            = lat.cmd;
  assign fb_addr_echo           = lat.addr;
  assign fb_response_data       = lat_data;
  assign fb_response_data_count = lat.count;
  assign fb_is_read_response    = lat.is_read;
  assign fb_build_response      = (state == ST_ISSUE);
  assign arb_busy               = (state != ST_IDLE);
  assign arb_owner              = owner_q;

endmodule

// File: tb/tb_response_arbiter.sv
// Directed bench for response_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16); timeout checks follow RESP_ARB_TIMEOUT_EN.
module tb_response_arbiter;
  import response_arbiter_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [1:0]             req_valid;
  logic [1:0]             req_ack;
  logic [1:0]             req_done;
  logic [1:0][7:0]        req_status;
  logic [1:0][7:0]        req_cmd;
  logic [1:0][31:0]       req_addr;
  logic [1:0][63:0][7:0]  req_data;
  logic [1:0][5:0]        req_data_count;
  logic [1:0]             req_is_read;
  logic [7:0]             fb_status_code;
  logic [7:0]             fb_cmd_echo;
  logic [31:0]            fb_addr_echo;
  logic [63:0][7:0]       fb_response_data;
  logic [5:0]             fb_response_data_count;
  logic                   fb_is_read_response;
  logic                   fb_build_response;
  logic                   fb_builder_busy;
  logic                   fb_response_complete;
  logic                   arb_busy;
  logic [0:0]             arb_owner;
  logic                   timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  response_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_ack                (req_ack),
    .req_done               (req_done),
    .req_status             (req_status),
    .req_cmd                (req_cmd),
    .req_addr               (req_addr),
    .req_data               (req_data),
    .req_data_count         (req_data_count),
    .req_is_read            (req_is_read),
    .fb_status_code         (fb_status_code),
    .fb_cmd_echo            (fb_cmd_echo),
    .fb_addr_echo           (fb_addr_echo),
    .fb_response_data       (fb_response_data),
    .fb_response_data_count (fb_response_data_count),
    .fb_is_read_response    (fb_is_read_response),
    .fb_build_response      (fb_build_response),
    .fb_builder_busy        (fb_builder_busy),
    .fb_response_complete   (fb_response_complete),
    .arb_busy               (arb_busy),
    .arb_owner              (arb_owner),
    .timeout_err            (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nxt; nxt;
    smp;
    n_checks++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", req_ack); end
    n_checks++; if (req_done !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b want 00", req_done); end
    n_checks++; if ({fb_build_response, arb_busy, arb_owner, timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL rst_ctrl: build=%b busy=%b owner=%b terr=%b want all 0", fb_build_response, arb_busy, arb_owner, timeout_err);
    end
    n_checks++; if ({fb_status_code, fb_cmd_echo, fb_addr_echo, fb_response_data_count, fb_is_read_response} !== 55'b0) begin
      n_fail++; $display("FAIL rst_fields: st=%h cmd=%h addr=%h cnt=%0d rd=%b want 0", fb_status_code, fb_cmd_echo, fb_addr_echo, fb_response_data_count, fb_is_read_response);
    end
    n_checks++; if (fb_response_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", fb_response_data); end
    nxt; rst = 1'b0;
    smp;
    n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b want 0", arb_busy); end
  endtask

  task automatic test_single;
    nxt;
    req_valid = 2'b01; req_status[0] = STATUS_OK; req_cmd[0] = 8'h20; req_is_read[0] = 1'b0; req_addr[0] = 32'h0;
    smp;
    n_checks++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", req_ack); end
    n_checks++; if (fb_build_response !== 1'b0) begin n_fail++; $display("FAIL single_build_early: got %b want 0", fb_build_response); end
    nxt; req_valid = 2'b00;
    smp;
    n_checks++; if ({fb_build_response, arb_busy, req_ack} !== 4'b1100) begin
      n_fail++; $display("FAIL single_issue: build=%b busy=%b ack=%b want 1 1 00", fb_build_response, arb_busy, req_ack);
    end
    n_checks++; if (fb_cmd_echo !== 8'h20) begin n_fail++; $display("FAIL single_cmd: got %h want 20", fb_cmd_echo); end
    nxt; smp;
    n_checks++; if (fb_build_response !== 1'b0) begin n_fail++; $display("FAIL single_build_once: got %b want 0", fb_build_response); end
    nxt; nxt; fb_response_complete = 1'b1;
    smp;
    n_checks++; if (req_done !== 2'b00) begin n_fail++; $display("FAIL single_done_early: got %b want 00", req_done); end
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", req_done); end
    nxt; smp;
    n_checks++; if ({req_done, arb_busy} !== 3'b000) begin n_fail++; $display("FAIL single_end: done=%b busy=%b want 00 0", req_done, arb_busy); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_oh;
    logic [7:0] exp_cmd;
    rst = 1'b1;
    nxt; nxt;
    rst = 1'b0;
    req_cmd[0] = 8'h10; req_cmd[1] = 8'h11;
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_oh  = 2'b01 << (f % 2);
      exp_cmd = (f % 2 == 1) ? 8'h11 : 8'h10;
      smp;
      n_checks++; if (req_ack !== exp_oh) begin n_fail++; $display("FAIL cont_ack[%0d]: got %b want %b", f, req_ack, exp_oh); end
      nxt; smp;
      n_checks++; if (fb_build_response !== 1'b1 || fb_cmd_echo !== exp_cmd || arb_owner !== exp_oh[1]) begin
        n_fail++; $display("FAIL cont_issue[%0d]: build=%b cmd=%h owner=%b want 1 %h %b", f, fb_build_response, fb_cmd_echo, arb_owner, exp_cmd, exp_oh[1]);
      end
      nxt; nxt; nxt; smp;
      n_checks++; if (fb_cmd_echo !== exp_cmd || req_ack !== 2'b00) begin
        n_fail++; $display("FAIL cont_hold[%0d]: cmd=%h ack=%b want %h 00", f, fb_cmd_echo, req_ack, exp_cmd);
      end
      nxt; fb_response_complete = 1'b1;
      smp;
      nxt; fb_response_complete = 1'b0;
      if (f == 3) req_valid = 2'b00;
      smp;
      n_checks++; if (req_done !== exp_oh) begin n_fail++; $display("FAIL cont_done[%0d]: got %b want %b", f, req_done, exp_oh); end
      nxt;
    end
    smp;
    n_checks++; if ({req_ack, arb_busy} !== 3'b000) begin n_fail++; $display("FAIL cont_end: ack=%b busy=%b want 00 0", req_ack, arb_busy); end
  endtask

  task automatic test_busy_builder;
    nxt; fb_builder_busy = 1'b1; req_valid = 2'b10;
    smp;
    n_checks++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL busy_ack0: got %b want 00", req_ack); end
    nxt; req_valid = 2'b11; fb_response_complete = 1'b1;
    smp;
    n_checks++; if ({req_ack, req_done, arb_busy} !== 5'b0) begin
      n_fail++; $display("FAIL busy_ignore: ack=%b done=%b busy=%b want 00 00 0", req_ack, req_done, arb_busy);
    end
    nxt; req_valid = 2'b10; fb_response_complete = 1'b0;
    smp;
    n_checks++; if ({req_done, arb_busy} !== 3'b000) begin n_fail++; $display("FAIL busy_stray: done=%b busy=%b want 00 0", req_done, arb_busy); end
    nxt; fb_builder_busy = 1'b0;
    smp;
    n_checks++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL busy_ack: got %b want 10", req_ack); end
    nxt; req_valid = 2'b00;
    smp;
    n_checks++; if (fb_build_response !== 1'b1) begin n_fail++; $display("FAIL busy_build: got %b want 1", fb_build_response); end
    nxt; fb_response_complete = 1'b1;
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b10) begin n_fail++; $display("FAIL busy_done: got %b want 10", req_done); end
    nxt; smp;
    n_checks++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL busy_withdrawn: got %b want 00", req_ack); end
  endtask

  task automatic test_read_payload;
    logic [63:0][7:0] exp_data;
    exp_data = '0;
    exp_data[0] = 8'hA1; exp_data[1] = 8'hB2; exp_data[2] = 8'hC3; exp_data[3] = 8'hD4;
    nxt;
    req_valid = 2'b10; req_status[1] = STATUS_OK; req_cmd[1] = 8'h03; req_addr[1] = 32'h1000_0040;
    req_data_count[1] = 6'd4; req_data[1] = exp_data; req_is_read[1] = 1'b1;
    smp;
    n_checks++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL read_ack: got %b want 10", req_ack); end
    nxt;
    req_valid = 2'b00; req_status[1] = 8'h7F; req_cmd[1] = 8'hEE; req_addr[1] = 32'hFFFF_FFFF;
    req_data_count[1] = 6'd63; req_data[1] = {64{8'hEE}}; req_is_read[1] = 1'b0;
    smp;
    n_checks++; if (fb_addr_echo !== 32'h1000_0040) begin n_fail++; $display("FAIL read_addr: got %h want 10000040", fb_addr_echo); end
    n_checks++; if (fb_response_data_count !== 6'd4) begin n_fail++; $display("FAIL read_count: got %0d want 4", fb_response_data_count); end
    n_checks++; if (fb_response_data !== exp_data) begin n_fail++; $display("FAIL read_data: got %h want %h", fb_response_data, exp_data); end
    n_checks++; if ({fb_is_read_response, fb_status_code, fb_cmd_echo, arb_owner} !== {1'b1, 8'h00, 8'h03, 1'b1}) begin
      n_fail++; $display("FAIL read_flags: rd=%b st=%h cmd=%h owner=%b want 1 00 03 1", fb_is_read_response, fb_status_code, fb_cmd_echo, arb_owner);
    end
    nxt; nxt; smp;
    n_checks++; if (fb_response_data !== exp_data || fb_addr_echo !== 32'h1000_0040) begin
      n_fail++; $display("FAIL read_stable: addr=%h data=%h", fb_addr_echo, fb_response_data);
    end
    nxt; fb_response_complete = 1'b1;
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b10) begin n_fail++; $display("FAIL read_done: got %b want 10", req_done); end
    nxt;
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 2'b01;
    nxt; req_valid = 2'b00;
    nxt; fb_response_complete = 1'b1;
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b01) begin n_fail++; $display("FAIL mid_pre_done: got %b want 01", req_done); end
    nxt;
    req_valid = 2'b11; req_cmd[0] = 8'h44; req_cmd[1] = 8'h55;
    smp;
    n_checks++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL mid_rr_prio: got %b want 10", req_ack); end
    nxt; nxt; nxt;
    smp;
    n_checks++; if (arb_busy !== 1'b1 || fb_cmd_echo !== 8'h55) begin
      n_fail++; $display("FAIL mid_wait: busy=%b cmd=%h want 1 55", arb_busy, fb_cmd_echo);
    end
    nxt; rst = 1'b1;
    nxt; smp;
    n_checks++; if ({arb_busy, req_done, arb_owner, fb_build_response, req_ack, timeout_err} !== 8'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: busy=%b done=%b owner=%b build=%b ack=%b terr=%b want all 0", arb_busy, req_done, arb_owner, fb_build_response, req_ack, timeout_err);
    end
    n_checks++; if (fb_cmd_echo !== 8'h00) begin n_fail++; $display("FAIL mid_rst_cmd: got %h want 00", fb_cmd_echo); end
    nxt; rst = 1'b0;
    smp;
    n_checks++; if (req_ack !== 2'b01 || req_done !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_rr: ack=%b done=%b want 01 00", req_ack, req_done);
    end
    nxt; req_valid = 2'b00;
    nxt; fb_response_complete = 1'b1;
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b01) begin n_fail++; $display("FAIL mid_post_done: got %b want 01", req_done); end
    nxt;
  endtask

  task automatic test_timeout;
    req_valid = 2'b10;
    smp;
    n_checks++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL to_ack: got %b want 10", req_ack); end
    nxt; req_valid = 2'b00;
`ifdef RESP_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      nxt;
      if (i == 16) begin
        smp;
        n_checks++; if ({req_done, timeout_err, arb_busy} !== 4'b0001) begin
          n_fail++; $display("FAIL to_wait16: done=%b terr=%b busy=%b want 00 0 1", req_done, timeout_err, arb_busy);
        end
      end
    end
    nxt; smp;
    n_checks++; if (req_done !== 2'b10 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_fire: done=%b terr=%b want 10 1", req_done, timeout_err);
    end
    nxt; nxt; nxt; smp;
    n_checks++; if (timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
      n_fail++; $display("FAIL to_sticky: terr=%b busy=%b want 1 0", timeout_err, arb_busy);
    end
`else
    for (int i = 1; i <= 40; i++) nxt;
    smp;
    n_checks++; if (timeout_err !== 1'b0 || arb_busy !== 1'b1 || req_done !== 2'b00) begin
      n_fail++; $display("FAIL to_none: terr=%b busy=%b done=%b want 0 1 00", timeout_err, arb_busy, req_done);
    end
    nxt; fb_response_complete = 1'b1;
    nxt; fb_response_complete = 1'b0;
    smp;
    n_checks++; if (req_done !== 2'b10) begin n_fail++; $display("FAIL to_late_done: got %b want 10", req_done); end
    nxt;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_status = '0; req_cmd = '0; req_addr = '0;
    req_data = '0; req_data_count = '0; req_is_read = '0;
    fb_builder_busy = 1'b0; fb_response_complete = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_busy_builder;
    test_read_payload;
    test_reset_mid_wait;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/response_arbiter.md
# response_arbiter

Shares the single response frame builder between NUM_REQ response sources, e.g. the command-parser error path and the AXI transaction path. Picks one pending request round-robin and latches its fields locally, which frees the requester immediately. It then issues one build command to the builder and waits for frame completion. Finally it reports completion back to the owning requester. Sits between the bridge's response producers and the frame builder that feeds the UART TX FIFO.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, 4096: builder-completion watchdog limit; used only when RESP_ARB_TIMEOUT_EN is defined.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [NUM_REQ]  request pending; held with fields stable until req_ack.
- req_ack  out  [NUM_REQ]  one-cycle pulse; fields latched this cycle.
- req_done  out  [NUM_REQ]  one-cycle pulse; owner's frame finished (or timed out).
- req_status  in  [NUM_REQ][8]  status code.
- req_cmd  in  [NUM_REQ][8]  command echo.
- req_addr  in  [NUM_REQ][32]  address echo.
- req_data  in  [NUM_REQ][64][8]  read data bytes.
- req_data_count  in  [NUM_REQ][6]  valid data bytes.
- req_is_read  in  [NUM_REQ]  read-response flag.
- fb_status_code, fb_cmd_echo  out  8 each  latched fields to builder.
- fb_addr_echo  out  32  latched address.
- fb_response_data  out  [64][8]  latched data.
- fb_response_data_count  out  6  latched count.
- fb_is_read_response  out  1  latched flag.
- fb_build_response  out  1  one-cycle build strobe.
- fb_builder_busy  in  1  builder not idle.
- fb_response_complete  in  1  builder frame-done pulse.
- arb_busy  out  1  state != IDLE.
- arb_owner  out  $clog2(NUM_REQ)  index of current/last owner.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requires any req_valid and !fb_builder_busy.
  - Winner is the first asserted index searching upward from rr_ptr, with wrap.
  - req_ack[winner]=1 combinationally in this cycle; all fields latched; arb_owner=winner.
  - Next state: ISSUE.
  - Without a winner, stay in IDLE.
- ISSUE: fb_build_response=1 for exactly one cycle; next state WAIT.
- WAIT: on fb_response_complete, go to DONE; otherwise stay.
- DONE:
  - req_done[arb_owner]=1.
  - rr_ptr = (arb_owner+1) mod NUM_REQ, wrapping at NUM_REQ-1 to 0.
  - Next state: IDLE.
- fb_* data outputs always reflect the latched registers. They change only on an ack.
- fb_response_complete outside WAIT is ignored.
- req_valid deasserted before ack simply withdraws the request (no ack issued).
- A requester re-asserting req_valid in the same cycle as its req_done is eligible in the next IDLE cycle, but at lowest priority.

## Timing
- Reset values:
  - All outputs 0; state IDLE; rr_ptr 0.
  - timeout_err 0; latched fields 0.
- Latency: req_valid (builder idle, arbiter idle) at cycle N gives req_ack at N and fb_build_response at N+1.
- Minimum turnaround: from fb_response_complete at cycle M, req_done is at M+1 and the next req_ack can be at M+2.
- Reset mid-frame returns the block to IDLE next edge, with no req_done. The builder shares rst.

## Configuration
- RESP_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - At count == TIMEOUT_CYCLES-1 with no completion, timeout_err sets (sticky until rst) and the state goes to DONE. req_done pulses normally.
  - The next issue still waits for !fb_builder_busy.
- Undefined: no counter; timeout_err tied 0; WAIT persists indefinitely.

## Structure
- Shared bridge package holds:
  - the arbiter state enum;
  - STATUS_OK (8'h00) and the device-to-host SOF (8'h5A) constants;
  - a response-request struct (status, cmd, addr, count, is_read).
- Sub-module rr_priority_picker: given req_valid and rr_ptr, outputs a one-hot grant and a winner index. Purely combinational; parameterised by NUM_REQ.

## Test plan
- Single request: req0 write (status 00, cmd 0x20, is_read 0), idle builder -> req_ack[0] at N, fb_build_response at N+1, req_done[0] one cycle after fb_response_complete.
- Contention: req0 and req1 valid together from reset -> grant order 0,1,0,1 over four frames; each frame stays latched while the loser holds.
- Busy builder: fb_builder_busy=1 with req1 valid -> no ack until busy drops; ack in the first idle cycle.
- Read payload: req1 read with addr 0x1000_0040, count 4, data A1 B2 C3 D4 -> fb_* show these exact values, unchanged after the requester changes its inputs post-ack.
- Reset mid-WAIT: rst asserted -> all outputs 0 next edge, no req_done, rr_ptr 0.
- With RESP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no completion -> timeout_err=1 after 16 WAIT cycles, req_done[owner] pulses, flag stays set.
